id_scoreboard: RTL and testbench

Register scoreboard and freeze controller for the ID stage of the 5-stage pipeline. It tracks every register write that has issued from ID but has not yet retired in WB, and drives `freez` to hold the IF/ID pipeline and bubble the ID controls whenever the instruction in ID reads a register with a pending write or memory is busy. It sits beside the ID stage. It takes decoded source and destination fields plus the WB write port, and produces the `freez` input of ID and the IF/ID register enables.

---
 rtl/id_scoreboard_if.sv | 29 ++
 rtl/id_scoreboard.sv | 86 ++++++++
 tb/tb_id_scoreboard.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_scoreboard_if.sv
// ID-stage scoreboard bundle: decoded ID fields, WB write port, and the
// freeze/pending/stall outputs shared between the ID stage and the scoreboard.
interface id_scoreboard_if;
  logic        issue_valid;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic        two_regs;
  logic [4:0]  id_dest;
  logic        id_wb_en;
  logic        flush;
  logic        mem_stall;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic        freez;
  logic [31:0] pending;
  logic [15:0] stall_count;

  modport master (
    output issue_valid, src1, src2, two_regs, id_dest, id_wb_en,
    output flush, mem_stall, wb_en, wb_dest,
    input  freez, pending, stall_count
  );

  modport slave (
    input  issue_valid, src1, src2, two_regs, id_dest, id_wb_en,
    input  flush, mem_stall, wb_en, wb_dest,
    output freez, pending, stall_count
  );
endinterface

// File: rtl/id_scoreboard.sv
// Register scoreboard for the ID stage: counts in-flight writes per register
// and raises a combinational freeze on RAW hazards, counter overflow or memory stall.
module id_scoreboard #(
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 2
) (
  input logic            clock,
  input logic            reset,
  id_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count      [32];
  logic [CNT_W-1:0] count_next [32];
  logic [31:0]      wb_hit;
  logic [31:0]      nonzero;
  logic [31:0]      busy;
  logic [31:0]      inc_vec;
  logic [31:0]      dec_vec;
  logic [31:0]      pending_next;
  logic             raw;
  logic             full;
  logic             issue;

  // A retiring write whose count is 1 no longer blocks when the register file writes early
  always_comb begin
    wb_hit  = '0;
    nonzero = '0;
    busy    = '0;
    for (int r = 1; r < 32; r++) begin
      wb_hit[r]  = WB_BYPASS && sb.wb_en && (sb.wb_dest == 5'(r));
      nonzero[r] = (count[r] != '0);
      busy[r]    = nonzero[r] && !((count[r] == CNT_ONE) && wb_hit[r]);
    end
  end

  assign raw = sb.issue_valid && (busy[sb.src1] || (sb.two_regs && busy[sb.src2]));

  assign full = sb.issue_valid && sb.id_wb_en && (sb.id_dest != 5'd0) &&
                (count[sb.id_dest] == CNT_MAX) && !wb_hit[sb.id_dest];

  assign sb.freez = sb.mem_stall || (!sb.flush && (raw || full));
  assign issue    = sb.issue_valid && !sb.flush && !sb.freez;

  // Simultaneous issue and retire on the same register cancel out
  always_comb begin
    inc_vec      = '0;
    dec_vec      = '0;
    pending_next = '0;
    for (int r = 0; r < 32; r++) begin
      count_next[r] = count[r];
    end
    count_next[0] = '0;
    for (int r = 1; r < 32; r++) begin
      inc_vec[r] = issue && sb.id_wb_en && (sb.id_dest == 5'(r));
      dec_vec[r] = sb.wb_en && (sb.wb_dest == 5'(r)) && nonzero[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        count_next[r] = count[r] + CNT_ONE;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        count_next[r] = count[r] - CNT_ONE;
      end
      pending_next[r] = (count_next[r] != '0);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) begin
        count[r] <= '0;
      end
      sb.pending     <= '0;
      sb.stall_count <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        count[r] <= count_next[r];
      end
      sb.pending <= pending_next;
      if (sb.freez && (sb.stall_count != 16'hFFFF)) begin
        sb.stall_count <= sb.stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: one instance with WB bypass, one without,
// each driven through its own interface with hand-computed expectations.
module tb_id_scoreboard;

  localparam int A = 0;
  localparam int B = 1;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  id_scoreboard_if if_a ();
  id_scoreboard_if if_b ();

  id_scoreboard #(.WB_BYPASS(1'b1), .CNT_W(2)) dut_a (
    .clock (clock),
    .reset (reset),
    .sb    (if_a.slave)
  );

  id_scoreboard #(.WB_BYPASS(1'b0), .CNT_W(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .sb    (if_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input int iv, input int s1, input int s2,
                       input int tr, input int dst, input int we, input int fl,
                       input int ms, input int wbe, input int wbd);
    if (sel == A) begin
      if_a.issue_valid = 1'(iv);
      if_a.src1        = 5'(s1);
      if_a.src2        = 5'(s2);
      if_a.two_regs    = 1'(tr);
      if_a.id_dest     = 5'(dst);
      if_a.id_wb_en    = 1'(we);
      if_a.flush       = 1'(fl);
      if_a.mem_stall   = 1'(ms);
      if_a.wb_en       = 1'(wbe);
      if_a.wb_dest     = 5'(wbd);
    end else begin
      if_b.issue_valid = 1'(iv);
      if_b.src1        = 5'(s1);
      if_b.src2        = 5'(s2);
      if_b.two_regs    = 1'(tr);
      if_b.id_dest     = 5'(dst);
      if_b.id_wb_en    = 1'(we);
      if_b.flush       = 1'(fl);
      if_b.mem_stall   = 1'(ms);
      if_b.wb_en       = 1'(wbe);
      if_b.wb_dest     = 5'(wbd);
    end
  endtask

  task automatic idle(input int sel);
    drive(sel, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    idle(A);
    idle(B);
    #2;

    // Reset state; freeze follows mem_stall while reset is held
    check("rst_pend_a",  if_a.pending, 32'h0);
    check("rst_stall_a", 32'(if_a.stall_count), 32'd0);
    check("rst_freez_a", 32'(if_a.freez), 32'd0);
    check("rst_pend_b",  if_b.pending, 32'h0);
    drive(A, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 check("rst_freez_ms", 32'(if_a.freez), 32'd1);
    idle(A);
    #1 check("rst_freez_clr", 32'(if_a.freez), 32'd0);
    tick();
    tick();
    reset = 1'b1;

    // Independent stream: r1 and r4 each pending for three cycles
    drive(A, 1, 2, 3, 1, 1, 1, 0, 0, 0, 0);
    #1 check("ind_freez0", 32'(if_a.freez), 32'd0);
    tick(); check("ind_pend0", if_a.pending, 32'h0000_0002);
    drive(A, 1, 5, 6, 1, 4, 1, 0, 0, 0, 0);
    #1 check("ind_freez1", 32'(if_a.freez), 32'd0);
    tick(); check("ind_pend1", if_a.pending, 32'h0000_0012);
    idle(A);
    tick(); check("ind_pend2", if_a.pending, 32'h0000_0012);
    drive(A, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tick(); check("ind_pend3", if_a.pending, 32'h0000_0010);
    drive(A, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    tick(); check("ind_pend4", if_a.pending, 32'h0);
    check("ind_stall", 32'(if_a.stall_count), 32'd0);

    // Back-to-back RAW on r5 with bypass: two freeze cycles, issue in the retire cycle
    drive(A, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0);
    #1 check("raw_freez_n", 32'(if_a.freez), 32'd0);
    tick(); check("raw_pend_n", if_a.pending, 32'h0000_0020);
    drive(A, 1, 5, 3, 1, 8, 1, 0, 0, 0, 0);
    #1 check("raw_freez_n1", 32'(if_a.freez), 32'd1);
    tick(); check("raw_pend_n1", if_a.pending, 32'h0000_0020);
    check("raw_stall_n1", 32'(if_a.stall_count), 32'd1);
    #1 check("raw_freez_n2", 32'(if_a.freez), 32'd1);
    tick(); check("raw_stall_n2", 32'(if_a.stall_count), 32'd2);
    drive(A, 1, 5, 3, 1, 8, 1, 0, 0, 1, 5);
    #1 check("raw_freez_n3", 32'(if_a.freez), 32'd0);
    tick(); check("raw_pend_n3", if_a.pending, 32'h0000_0100);
    check("raw_stall_n3", 32'(if_a.stall_count), 32'd2);
    idle(A);
    tick();
    tick();
    drive(A, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8);
    tick(); check("raw_drain", if_a.pending, 32'h0);

    // Register 0 is never tracked
    drive(A, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    #1 check("r0_freez0", 32'(if_a.freez), 32'd0);
    tick(); check("r0_pend0", if_a.pending, 32'h0);
    drive(A, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    #1 check("r0_freez1", 32'(if_a.freez), 32'd0);
    tick(); check("r0_pend1", if_a.pending, 32'h0);

    // Stray retire on an idle register must not wrap the count
    drive(A, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    tick(); check("uf_pend0", if_a.pending, 32'h0);
    drive(A, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);
    tick(); check("uf_pend1", if_a.pending, 32'h0000_0008);
    drive(A, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    tick(); check("uf_pend2", if_a.pending, 32'h0);

    // Counter saturation on r7: fourth writer waits, then issues alongside a retire
    for (int i = 0; i < 3; i++) begin
      drive(A, 1, 1, 2, 1, 7, 1, 0, 0, 0, 0);
      #1 check("full_freez_w", 32'(if_a.freez), 32'd0);
      tick();
    end
    check("full_pend3", if_a.pending, 32'h0000_0080);
    drive(A, 1, 1, 2, 1, 7, 1, 0, 0, 0, 0);
    #1 check("full_freez4", 32'(if_a.freez), 32'd1);
    tick(); check("full_stall", 32'(if_a.stall_count), 32'd3);
    drive(A, 1, 1, 2, 1, 7, 1, 0, 0, 1, 7);
    #1 check("full_freez_ret", 32'(if_a.freez), 32'd0);
    tick(); check("full_pend_ret", if_a.pending, 32'h0000_0080);
    drive(A, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    tick(); check("full_drain1", if_a.pending, 32'h0000_0080);
    tick(); check("full_drain2", if_a.pending, 32'h0000_0080);
    tick(); check("full_drain3", if_a.pending, 32'h0);

    // src2 only matters when the instruction actually reads it
    drive(A, 1, 1, 2, 1, 9, 1, 0, 0, 0, 0);
    tick(); check("tr_pend0", if_a.pending, 32'h0000_0200);
    drive(A, 1, 1, 9, 0, 10, 1, 0, 0, 0, 0);
    #1 check("tr_freez_imm", 32'(if_a.freez), 32'd0);
    tick(); check("tr_pend1", if_a.pending, 32'h0000_0600);
    drive(A, 1, 1, 9, 1, 10, 1, 0, 0, 0, 0);
    #1 check("tr_freez_reg", 32'(if_a.freez), 32'd1);
    tick(); check("tr_pend2", if_a.pending, 32'h0000_0600);
    check("tr_stall", 32'(if_a.stall_count), 32'd4);
    drive(A, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    tick(); check("tr_pend3", if_a.pending, 32'h0000_0400);
    drive(A, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10);
    tick(); check("tr_pend4", if_a.pending, 32'h0);

    // Flush beats a hazard; mem_stall beats flush; reset mid-stall clears state at once
    drive(A, 1, 1, 2, 1, 11, 1, 0, 0, 0, 0);
    tick(); check("fl_pend0", if_a.pending, 32'h0000_0800);
    drive(A, 1, 11, 2, 1, 12, 1, 1, 0, 0, 0);
    #1 check("fl_freez", 32'(if_a.freez), 32'd0);
    tick(); check("fl_pend1", if_a.pending, 32'h0000_0800);
    check("fl_stall", 32'(if_a.stall_count), 32'd4);
    drive(A, 1, 11, 2, 1, 12, 1, 1, 1, 0, 0);
    #1 check("ms_freez", 32'(if_a.freez), 32'd1);
    tick(); check("ms_stall", 32'(if_a.stall_count), 32'd5);
    check("ms_pend", if_a.pending, 32'h0000_0800);
    drive(A, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    reset = 1'b0;
    #1 check("mr_pend", if_a.pending, 32'h0);
    check("mr_stall", 32'(if_a.stall_count), 32'd0);
    check("mr_freez", 32'(if_a.freez), 32'd1);
    idle(A);
    #1 check("mr_freez_clr", 32'(if_a.freez), 32'd0);
    tick();
    reset = 1'b1;
    tick(); check("mr_stall_post", 32'(if_a.stall_count), 32'd0);

    // Without bypass the dependent instruction waits one extra cycle
    drive(B, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0);
    #1 check("nb_freez_n", 32'(if_b.freez), 32'd0);
    tick(); check("nb_pend_n", if_b.pending, 32'h0000_0020);
    drive(B, 1, 5, 3, 1, 8, 1, 0, 0, 0, 0);
    #1 check("nb_freez_n1", 32'(if_b.freez), 32'd1);
    tick();
    #1 check("nb_freez_n2", 32'(if_b.freez), 32'd1);
    tick(); check("nb_stall_n2", 32'(if_b.stall_count), 32'd2);
    drive(B, 1, 5, 3, 1, 8, 1, 0, 0, 1, 5);
    #1 check("nb_freez_n3", 32'(if_b.freez), 32'd1);
    tick(); check("nb_pend_n3", if_b.pending, 32'h0);
    drive(B, 1, 5, 3, 1, 8, 1, 0, 0, 0, 0);
    #1 check("nb_freez_n4", 32'(if_b.freez), 32'd0);
    tick(); check("nb_pend_n4", if_b.pending, 32'h0000_0100);
    check("nb_stall_n4", 32'(if_b.stall_count), 32'd3);
    check("nb_a_quiet", if_a.pending, 32'h0);
    idle(B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
